dma_priority_arbiter: RTL and testbench

//  Channel arbitration and bus-hold stage of the 4-channel DMA controller.
//  - Collects hardware DREQ and software requests, applies the mask register and resolves one winner.
//  - Resolution is fixed or rotating priority.
//  - Runs the HRQ/HLDA hold handshake with the CPU and drives DACK for the granted channel.
//  - Sits between the register file and the timing-control state machine.
//  - Its DACK/HRQ/priorityOrder outputs are what the controller-level SVA checker observes.

---
 rtl/dma_priority_arbiter.sv | 120 ++++++++++++
 tb/tb_dma_priority_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_priority_arbiter.sv
// Channel arbitration and bus-hold stage of the 4-channel DMA controller:
// masks/merges requests, picks a fixed or rotating-priority winner and runs HRQ/HLDA.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_CH-1:0]        DREQ,
    input  logic [NUM_CH-1:0]        maskReg,
    input  logic [NUM_CH-1:0]        requestReg,
    input  logic                     priorityType,
    input  logic                     controllerDisable,
    input  logic                     HLDA,
    input  logic                     serviceDone,
    output logic                     HRQ,
    output logic [NUM_CH-1:0]        DACK,
    output logic [CH_W-1:0]          activeChannel,
    output logic                     grantValid,
    output logic [NUM_CH*CH_W-1:0]   priorityOrder
);

    localparam logic [NUM_CH*CH_W-1:0] DEFAULT_ORDER = 8'b11_10_01_00;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GRANT,
        RELEASE
    } stateT;

    stateT                   state;
    stateT                   stateNext;
    logic [NUM_CH-1:0]       pending;
    logic [CH_W-1:0]         winner;
    logic [CH_W-1:0]         grantChNext;
    logic [NUM_CH-1:0]       dackNext;
    logic [NUM_CH*CH_W-1:0]  orderNext;
    logic                    rotate;

    // Scan slots lowest priority first so the highest-priority pending channel is the last write.
    always_comb begin
        pending = controllerDisable ? '0 : ((DREQ & ~maskReg) | requestReg);
        winner  = priorityOrder[CH_W-1:0];
        for (int s = NUM_CH - 1; s >= 0; s--) begin
            if (pending[priorityOrder[CH_W*s +: CH_W]]) begin
                winner = priorityOrder[CH_W*s +: CH_W];
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext   = state;
        grantChNext = activeChannel;
        rotate      = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) stateNext = REQ;
            end
            REQ: begin
                // HRQ is never withdrawn before HLDA, so only HLDA moves us on.
                if (HLDA) begin
                    if (|pending) begin
                        stateNext   = GRANT;
                        grantChNext = winner;
                    end else begin
                        stateNext = RELEASE;
                    end
                end
            end
            GRANT: begin
                if (serviceDone) begin
                    stateNext = RELEASE;
                    rotate    = priorityType;
                end else if (!HLDA) begin
                    stateNext = IDLE;
                end
            end
            RELEASE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        dackNext = '0;
        if (stateNext == GRANT) dackNext[grantChNext] = 1'b1;

        // The serviced channel drops to lowest priority; its successor becomes highest.
        if (!priorityType) begin
            orderNext = DEFAULT_ORDER;
        end else if (rotate) begin
            orderNext = {activeChannel, activeChannel + 2'd3, activeChannel + 2'd2, activeChannel + 2'd1};
        end else begin
            orderNext = priorityOrder;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            HRQ           <= 1'b0;
            DACK          <= '0;
            activeChannel <= '0;
            grantValid    <= 1'b0;
            priorityOrder <= DEFAULT_ORDER;
        end else begin
            state         <= stateNext;
            HRQ           <= (stateNext == REQ) || (stateNext == GRANT);
            DACK          <= dackNext;
            activeChannel <= (stateNext == GRANT) ? grantChNext : '0;
            grantValid    <= (stateNext == GRANT);
            priorityOrder <= orderNext;
        end
    end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed scenarios plus randomized
// stimulus compared every cycle against a list-based behavioural model.
module tb_dma_priority_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ;
    logic [3:0] maskReg;
    logic [3:0] requestReg;
    logic       priorityType;
    logic       controllerDisable;
    logic       HLDA;
    logic       serviceDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] activeChannel;
    logic       grantValid;
    logic [7:0] priorityOrder;

    int nChecks = 0;
    int nPass   = 0;

    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_GRANT = 2;
    localparam int M_REL  = 3;

    // Model: bus phase, owning channel, and priority list (index 0 = highest).
    int mPhase;
    int mOwner;
    int mOrder[4];

    always #5 CLK = ~CLK;

    dma_priority_arbiter dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .DREQ             (DREQ),
        .maskReg          (maskReg),
        .requestReg       (requestReg),
        .priorityType     (priorityType),
        .controllerDisable(controllerDisable),
        .HLDA             (HLDA),
        .serviceDone      (serviceDone),
        .HRQ              (HRQ),
        .DACK             (DACK),
        .activeChannel    (activeChannel),
        .grantValid       (grantValid),
        .priorityOrder    (priorityOrder)
    );

    task automatic modelReset();
        mPhase = M_IDLE;
        mOwner = 0;
        for (int s = 0; s < 4; s++) mOrder[s] = s;
    endtask

    // Advance one clock in both model and DUT, then compare every output.
    task automatic step(input string tag);
        logic [3:0] pend;
        logic [3:0] expDack;
        logic [7:0] expOrder;
        int nextPhase;
        bit served;
        pend = controllerDisable ? 4'b0000 : ((DREQ & ~maskReg) | requestReg);
        nextPhase = mPhase;
        served = 1'b0;
        if (RESET) begin
            modelReset();
        end else begin
            case (mPhase)
                M_IDLE: if (pend != 0) nextPhase = M_REQ;
                M_REQ: begin
                    if (HLDA) begin
                        if (pend != 0) begin
                            for (int s = 0; s < 4; s++) begin
                                if (pend[mOrder[s]]) begin
                                    mOwner = mOrder[s];
                                    break;
                                end
                            end
                            nextPhase = M_GRANT;
                        end else begin
                            nextPhase = M_REL;
                        end
                    end
                end
                M_GRANT: begin
                    if (serviceDone) begin
                        nextPhase = M_REL;
                        served = 1'b1;
                    end else if (!HLDA) begin
                        nextPhase = M_IDLE;
                    end
                end
                default: nextPhase = M_IDLE;
            endcase
            if (!priorityType) begin
                for (int s = 0; s < 4; s++) mOrder[s] = s;
            end else if (served) begin
                for (int s = 0; s < 4; s++) mOrder[s] = (mOwner + 1 + s) % 4;
            end
            mPhase = nextPhase;
        end

        @(posedge CLK);
        #1;

        expDack  = (mPhase == M_GRANT) ? 4'(1 << mOwner) : 4'b0000;
        expOrder = 8'(mOrder[0] + 4 * mOrder[1] + 16 * mOrder[2] + 64 * mOrder[3]);

        nChecks++;
        if (HRQ !== (mPhase == M_REQ || mPhase == M_GRANT))
            $display("FAIL %s model_hrq: got %b want %b", tag, HRQ, (mPhase == M_REQ || mPhase == M_GRANT));
        else nPass++;
        nChecks++;
        if (grantValid !== (mPhase == M_GRANT))
            $display("FAIL %s model_grantValid: got %b want %b", tag, grantValid, (mPhase == M_GRANT));
        else nPass++;
        nChecks++;
        if (DACK !== expDack)
            $display("FAIL %s model_dack: got %b want %b", tag, DACK, expDack);
        else nPass++;
        nChecks++;
        if (activeChannel !== ((mPhase == M_GRANT) ? 2'(mOwner) : 2'd0))
            $display("FAIL %s model_activeChannel: got %0d want %0d", tag, activeChannel,
                     (mPhase == M_GRANT) ? mOwner : 0);
        else nPass++;
        nChecks++;
        if (priorityOrder !== expOrder)
            $display("FAIL %s model_priorityOrder: got %h want %h", tag, priorityOrder, expOrder);
        else nPass++;
        nChecks++;
        if ((DACK & (DACK - 4'd1)) !== 4'b0000 || (DACK != 0 && !(HRQ && grantValid)))
            $display("FAIL %s invariant_dack: DACK=%b HRQ=%b grantValid=%b", tag, DACK, HRQ, grantValid);
        else nPass++;
    endtask

    task automatic idleInputs();
        DREQ = 4'b0000;
        maskReg = 4'b0000;
        requestReg = 4'b0000;
        controllerDisable = 1'b0;
        HLDA = 1'b0;
        serviceDone = 1'b0;
    endtask

    task automatic doReset();
        RESET = 1'b1;
        step("reset");
        RESET = 1'b0;
    endtask

    task automatic waitGrant(input string tag);
        int n = 0;
        while (!grantValid && n < 10) begin
            step(tag);
            n++;
        end
        nChecks++;
        if (!grantValid) $display("FAIL %s grant_timeout: grantValid got %b want 1", tag, grantValid);
        else nPass++;
    endtask

    task automatic test_reset();
        idleInputs();
        priorityType = 1'b0;
        modelReset();
        doReset();
        nChecks++;
        if ({HRQ, DACK, grantValid, priorityOrder} !== {1'b0, 4'b0000, 1'b0, 8'hE4})
            $display("FAIL reset_values: got HRQ=%b DACK=%b gv=%b order=%h want 0 0000 0 e4",
                     HRQ, DACK, grantValid, priorityOrder);
        else nPass++;
    endtask

    task automatic test_fixed();
        logic [3:0] expDack;
        idleInputs();
        priorityType = 1'b0;
        DREQ = 4'b1010;
        step("fixed_req");
        nChecks++;
        if (HRQ !== 1'b1) $display("FAIL fixed_hrq: got %b want 1", HRQ);
        else nPass++;
        step("fixed_wait");
        step("fixed_wait");
        HLDA = 1'b1;
        step("fixed_hlda");
        nChecks++;
        if (DACK !== 4'b0010) $display("FAIL fixed_dack: got %b want 0010", DACK);
        else nPass++;
        serviceDone = 1'b1;
        DREQ = 4'b0000;
        step("fixed_done");
        serviceDone = 1'b0;
        step("fixed_idle");

        for (int v = 0; v < 16; v++) begin
            DREQ = 4'(v);
            HLDA = 1'b1;
            step("sweep");
            step("sweep");
            expDack = 4'b0000;
            for (int b = 3; b >= 0; b--) if (v[b]) expDack = 4'(1 << b);
            nChecks++;
            if (DACK !== expDack || HRQ !== (v != 0))
                $display("FAIL sweep_%0d: got DACK=%b HRQ=%b want DACK=%b HRQ=%b", v, DACK, HRQ, expDack, v != 0);
            else nPass++;
            serviceDone = 1'b1;
            DREQ = 4'b0000;
            step("sweep_done");
            serviceDone = 1'b0;
            step("sweep_idle");
        end
        HLDA = 1'b0;
        step("fixed_end");
    endtask

    task automatic test_rotating();
        idleInputs();
        priorityType = 1'b1;
        doReset();
        DREQ = 4'b1111;
        HLDA = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitGrant("rotate_wait");
            nChecks++;
            if (DACK !== 4'(1 << i)) $display("FAIL rotate_dack_%0d: got %b want %b", i, DACK, 4'(1 << i));
            else nPass++;
            serviceDone = 1'b1;
            step("rotate_done");
            serviceDone = 1'b0;
            if (i == 0) begin
                nChecks++;
                if (priorityOrder !== 8'b00_11_10_01)
                    $display("FAIL rotate_order_first: got %b want 00111001", priorityOrder);
                else nPass++;
            end
        end
        DREQ = 4'b0000;
        step("rotate_end");
        step("rotate_end");
        HLDA = 1'b0;
        step("rotate_end");
    endtask

    task automatic test_mask();
        idleInputs();
        priorityType = 1'b0;
        doReset();
        maskReg = 4'b0001;
        DREQ = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step("mask_hold");
            nChecks++;
            if (HRQ !== 1'b0) $display("FAIL mask_hrq_%0d: got %b want 0", i, HRQ);
            else nPass++;
        end
        requestReg = 4'b0001;
        step("mask_swreq");
        nChecks++;
        if (HRQ !== 1'b1) $display("FAIL mask_swreq_hrq: got %b want 1", HRQ);
        else nPass++;
        HLDA = 1'b1;
        step("mask_hlda");
        nChecks++;
        if (DACK !== 4'b0001) $display("FAIL mask_swreq_dack: got %b want 0001", DACK);
        else nPass++;
        serviceDone = 1'b1;
        requestReg = 4'b0000;
        DREQ = 4'b0000;
        step("mask_done");
        idleInputs();
        step("mask_end");
    endtask

    task automatic test_abort();
        idleInputs();
        priorityType = 1'b1;
        doReset();
        DREQ = 4'b0100;
        HLDA = 1'b1;
        waitGrant("abort_wait");
        nChecks++;
        if (DACK !== 4'b0100) $display("FAIL abort_grant: got %b want 0100", DACK);
        else nPass++;
        HLDA = 1'b0;
        step("abort_drop");
        nChecks++;
        if ({DACK, HRQ, priorityOrder} !== {4'b0000, 1'b0, 8'hE4})
            $display("FAIL abort_state: got DACK=%b HRQ=%b order=%h want 0000 0 e4", DACK, HRQ, priorityOrder);
        else nPass++;
        step("abort_rereq");
        HLDA = 1'b1;
        step("abort_regrant");
        nChecks++;
        if (DACK !== 4'b0100) $display("FAIL abort_regrant: got %b want 0100", DACK);
        else nPass++;
        HLDA = 1'b0;
        serviceDone = 1'b1;
        step("abort_done_wins");
        nChecks++;
        if ({DACK, HRQ, grantValid, priorityOrder} !== {4'b0000, 1'b0, 1'b0, 8'b10_01_00_11})
            $display("FAIL abort_done_wins: got DACK=%b HRQ=%b gv=%b order=%b want 0000 0 0 10010011",
                     DACK, HRQ, grantValid, priorityOrder);
        else nPass++;
        idleInputs();
        step("abort_end");
    endtask

    task automatic test_req_reset();
        bit sawDack = 1'b0;
        idleInputs();
        priorityType = 1'b0;
        doReset();
        DREQ = 4'b0001;
        step("reqrst_req");
        nChecks++;
        if (HRQ !== 1'b1) $display("FAIL reqrst_hrq: got %b want 1", HRQ);
        else nPass++;
        RESET = 1'b1;
        step("reqrst_reset");
        RESET = 1'b0;
        nChecks++;
        if ({HRQ, DACK, grantValid, activeChannel, priorityOrder} !== {1'b0, 4'b0000, 1'b0, 2'd0, 8'hE4})
            $display("FAIL reqrst_outputs: got HRQ=%b DACK=%b gv=%b ch=%0d order=%h", HRQ, DACK, grantValid,
                     activeChannel, priorityOrder);
        else nPass++;
        step("reqrst_req2");
        DREQ = 4'b0000;
        step("reqrst_drop");
        sawDack |= (DACK != 0);
        nChecks++;
        if (HRQ !== 1'b1) $display("FAIL reqrst_hold_hrq: got %b want 1", HRQ);
        else nPass++;
        HLDA = 1'b1;
        step("reqrst_release");
        sawDack |= (DACK != 0);
        nChecks++;
        if ({HRQ, grantValid} !== 2'b00) $display("FAIL reqrst_release: got HRQ=%b gv=%b want 0 0", HRQ, grantValid);
        else nPass++;
        step("reqrst_idle");
        sawDack |= (DACK != 0);
        nChecks++;
        if (sawDack) $display("FAIL reqrst_no_dack: got DACK asserted want never");
        else nPass++;
        idleInputs();
        step("reqrst_end");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            RESET = ($urandom_range(0, 63) == 0);
            DREQ = 4'($urandom);
            maskReg = 4'($urandom);
            requestReg = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            controllerDisable = ($urandom_range(0, 7) == 0);
            HLDA = ($urandom_range(0, 3) != 0);
            serviceDone = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 99) == 0) priorityType = ~priorityType;
            step("random");
        end
    endtask

    initial begin
        RESET = 1'b1;
        priorityType = 1'b0;
        idleInputs();
        test_reset();
        test_fixed();
        test_rotating();
        test_mask();
        test_abort();
        test_req_reset();
        priorityType = 1'b1;
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
